// File: rtl/lockin_csr_bank.sv
// Control/status register bank for a multi-channel lock-in amplifier: static config,
// double-buffered DDS phase registers with optional frame-synchronous commit, and X/Y snapshots.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no commit outstanding; COMMIT with sync_mode=0 applies at once
// ST_PENDING | commit armed, shadows copy to active on the next sync_pulse
module lockin_csr_bank #(
    parameter int N_CH    = 8,
    parameter int PHASE_W = 20,
    parameter int LIA_W   = 16
) (
    input  logic                       clk_clk,
    input  logic                       reset_reset,
    input  logic [6:0]                 avs_address,
    input  logic                       avs_write,
    input  logic                       avs_read,
    input  logic [31:0]                avs_writedata,
    output logic [31:0]                avs_readdata,
    input  logic                       sync_pulse,
    input  logic                       lia_valid,
    input  logic [N_CH*LIA_W-1:0]      lia_x_export,
    input  logic [N_CH*LIA_W-1:0]      lia_y_export,
    output logic [N_CH*PHASE_W-1:0]    phase_incr_export,
    output logic [N_CH*PHASE_W-1:0]    phase_offs_export,
    output logic [7:0]                 control_bits_export,
    output logic [5:0]                 gain_ctrl_export,
    output logic [7:0]                 dac_gain_export,
    output logic [7:0]                 dac_div_export
);

    localparam logic [6:0] ADDR_CONTROL  = 7'h00;
    localparam logic [6:0] ADDR_GAIN     = 7'h01;
    localparam logic [6:0] ADDR_DAC_GAIN = 7'h02;
    localparam logic [6:0] ADDR_DAC_DIV  = 7'h03;
    localparam logic [6:0] ADDR_CMD      = 7'h04;
    localparam logic [6:0] ADDR_STATUS   = 7'h05;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } commit_state_t;

    commit_state_t state;

    logic                      sync_mode;
    logic                      snap_pending;
    logic                      snap_valid;
    logic [PHASE_W-1:0]        incr_sh  [N_CH];
    logic [PHASE_W-1:0]        offs_sh  [N_CH];
    logic [PHASE_W-1:0]        incr_act [N_CH];
    logic [PHASE_W-1:0]        offs_act [N_CH];
    logic signed [LIA_W-1:0]   snap_x   [N_CH];
    logic signed [LIA_W-1:0]   snap_y   [N_CH];

    logic        is_phase;
    logic        is_snap;
    logic [3:0]  ch;
    logic        cmd_wr;
    logic        cmd_commit;
    logic        cmd_snap;
    logic        mode_next;
    logic        do_apply;
    logic [31:0] rd_mux;
    logic        unused_wdata;

    // Phase block starts at 0x10, so subtracting 8 from addr[4:1] yields the channel index.
    assign is_phase   = (avs_address >= 7'h10) && (avs_address < 7'h30);
    assign is_snap    = (avs_address >= 7'h40) && (avs_address < 7'h60);
    assign ch         = is_snap ? avs_address[4:1] : (avs_address[4:1] - 4'd8);
    assign cmd_wr     = avs_write && (avs_address == ADDR_CMD);
    assign cmd_commit = cmd_wr && avs_writedata[0];
    assign cmd_snap   = cmd_wr && avs_writedata[1];
    assign mode_next  = cmd_wr ? avs_writedata[2] : sync_mode;

    assign unused_wdata = ^avs_writedata;

    // A pending commit fires on sync_pulse, or at once if the same CMD write drops sync_mode.
    always_comb begin
        do_apply = 1'b0;
        case (state)
            ST_IDLE:    do_apply = cmd_commit && !avs_writedata[2];
            ST_PENDING: do_apply = sync_pulse || !mode_next;
            default:    do_apply = 1'b0;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state     <= ST_IDLE;
            sync_mode <= 1'b0;
        end else begin
            if (cmd_wr)
                sync_mode <= avs_writedata[2];
            case (state)
                ST_IDLE: begin
                    if (cmd_commit && avs_writedata[2])
                        state <= ST_PENDING;
                end
                ST_PENDING: begin
                    if (do_apply)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            control_bits_export <= '0;
            gain_ctrl_export    <= '0;
            dac_gain_export     <= '0;
            dac_div_export      <= '0;
        end else if (avs_write) begin
            case (avs_address)
                ADDR_CONTROL:  control_bits_export <= avs_writedata[7:0];
                ADDR_GAIN:     gain_ctrl_export    <= avs_writedata[5:0];
                ADDR_DAC_GAIN: dac_gain_export     <= avs_writedata[7:0];
                ADDR_DAC_DIV:  dac_div_export      <= avs_writedata[7:0];
                default: ;
            endcase
        end
    end

    // Apply reads the shadows' pre-edge values, so a colliding shadow write lands only in the shadow.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            for (int k = 0; k < N_CH; k++) begin
                incr_sh[k]  <= '0;
                offs_sh[k]  <= '0;
                incr_act[k] <= '0;
                offs_act[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (avs_write && is_phase && (ch == 4'(k))) begin
                    if (avs_address[0])
                        offs_sh[k] <= avs_writedata[PHASE_W-1:0];
                    else
                        incr_sh[k] <= avs_writedata[PHASE_W-1:0];
                end
                if (do_apply) begin
                    incr_act[k] <= incr_sh[k];
                    offs_act[k] <= offs_sh[k];
                end
            end
        end
    end

    // A SNAP arms capture only from the next edge on; a same-edge lia_valid is not taken.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            snap_pending <= 1'b0;
            snap_valid   <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
                snap_x[k] <= '0;
                snap_y[k] <= '0;
            end
        end else if (snap_pending) begin
            if (lia_valid) begin
                snap_pending <= 1'b0;
                snap_valid   <= 1'b1;
                for (int k = 0; k < N_CH; k++) begin
                    snap_x[k] <= lia_x_export[k*LIA_W +: LIA_W];
                    snap_y[k] <= lia_y_export[k*LIA_W +: LIA_W];
                end
            end
        end else if (cmd_snap) begin
            snap_pending <= 1'b1;
            snap_valid   <= 1'b0;
        end
    end

    always_comb begin
        rd_mux = '0;
        if (is_phase) begin
            for (int k = 0; k < N_CH; k++) begin
                if (ch == 4'(k))
                    rd_mux = avs_address[0] ? 32'(offs_sh[k]) : 32'(incr_sh[k]);
            end
        end else if (is_snap) begin
            for (int k = 0; k < N_CH; k++) begin
                if (ch == 4'(k))
                    rd_mux = avs_address[0] ? 32'($signed(snap_y[k])) : 32'($signed(snap_x[k]));
            end
        end else begin
            case (avs_address)
                ADDR_CONTROL:  rd_mux = 32'(control_bits_export);
                ADDR_GAIN:     rd_mux = 32'(gain_ctrl_export);
                ADDR_DAC_GAIN: rd_mux = 32'(dac_gain_export);
                ADDR_DAC_DIV:  rd_mux = 32'(dac_div_export);
                ADDR_STATUS:   rd_mux = {28'd0, sync_mode, snap_valid, snap_pending,
                                         state == ST_PENDING};
                default:       rd_mux = '0;
            endcase
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)
            avs_readdata <= '0;
        else if (avs_read)
            avs_readdata <= rd_mux;
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_export
        assign phase_incr_export[g*PHASE_W +: PHASE_W] = incr_act[g];
        assign phase_offs_export[g*PHASE_W +: PHASE_W] = offs_act[g];
    end

endmodule
